// File: rtl/gd_update_sequencer.sv
// gd_update_sequencer: streams weight/gradient pairs to a gradient_descent responder and writes results back
module gd_update_sequencer #(
  parameter int N_WEIGHTS = 4,
  parameter int ADDR_W = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [15:0]       lr_in,
  input  logic [15:0]       grad_in,
  input  logic              grad_valid_in,
  output logic              grad_ready_out,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [15:0]       rd_data_in,
  output logic [15:0]       gd_lr_out,
  output logic [15:0]       gd_w_old_out,
  output logic [15:0]       gd_grad_out,
  output logic              gd_start_out,
  input  logic [15:0]       gd_w_updated_in,
  input  logic              gd_done_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [15:0]       wr_data_out,
  output logic              busy_out,
  output logic              done_out
);
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] NW = CW'(N_WEIGHTS);
  localparam logic [ADDR_W:0] LAST = CW'(N_WEIGHTS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] iss_cnt, wr_cnt;
  logic [ADDR_W-1:0] addr_d, f0, f1;
  logic [1:0] fcnt, fslot;
  logic hs, pop, go;
  assign go = state == IDLE && start_in;
  assign grad_ready_out = state == RUN && iss_cnt < NW;
  assign hs = grad_valid_in && grad_ready_out;
  assign rd_en_out = hs;
  assign rd_addr_out = iss_cnt[ADDR_W-1:0];
  assign pop = gd_done_in && fcnt != 2'd0;
  assign fslot = fcnt - {1'b0, pop};
  assign gd_w_old_out = gd_start_out ? rd_data_in : '0;
  assign busy_out = state == RUN || state == DRAIN;
  assign done_out = state == DONE;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = go ? RUN :
              (state == RUN && hs && iss_cnt == LAST) ? DRAIN :
              (state == DRAIN && wr_cnt == NW) ? DONE :
              (state == DONE) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (!rst) begin
      gd_lr_out <= '0;
      iss_cnt <= '0;
      wr_cnt <= '0;
      gd_start_out <= 1'b0;
      gd_grad_out <= '0;
      addr_d <= '0;
      f0 <= '0;
      f1 <= '0;
      fcnt <= '0;
      wr_en_out <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      if (go) begin
        gd_lr_out <= lr_in;
        iss_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (hs) iss_cnt <= iss_cnt + 1'b1;
        if (pop) wr_cnt <= wr_cnt + 1'b1;
      end
      gd_start_out <= hs;
      if (hs) begin
        gd_grad_out <= grad_in;
        addr_d <= iss_cnt[ADDR_W-1:0];
      end
      if (pop) f0 <= f1;
      if (gd_start_out) begin
        if (fslot == 2'd0) f0 <= addr_d;
        else f1 <= addr_d;
      end
      fcnt <= fcnt + {1'b0, gd_start_out} - {1'b0, pop};
      wr_en_out <= pop;
      if (pop) begin
        wr_addr_out <= f0;
        wr_data_out <= gd_w_updated_in;
      end
    end
  end
endmodule

// File: tb/tb_gd_update_sequencer.sv
// tb_gd_update_sequencer: directed vector and burst-sequence checks with weight-memory and Q8.8 responder models
module tb_gd_update_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_in = 1'b0;
  logic [15:0] lr_in = '0;
  logic [15:0] grad_in = '0;
  logic grad_valid_in = 1'b0;
  logic grad_ready_out, rd_en_out, gd_start_out, wr_en_out, busy_out, done_out;
  logic [1:0] rd_addr_out, wr_addr_out;
  logic [15:0] rd_data_in = '0;
  logic [15:0] gd_lr_out, gd_w_old_out, gd_grad_out, wr_data_out;
  logic [15:0] gd_w_updated_in = '0;
  logic gd_done_in = 1'b0;
  logic load = 1'b0;
  logic spur = 1'b0;
  logic [15:0] mem [4];
  int n_pass = 0, n_tot = 0;
  int cyc = 0, n_start = 0, n_wr = 0, n_done = 0, done_at = 0;
  int wlog [64];
  typedef struct {
    logic st; logic vl; logic [15:0] lr;
    logic rdy; logic rd; logic [1:0] ra; logic gs; logic [15:0] wo;
    logic we; logic [1:0] wa; logic [15:0] wd; logic dn; logic [1:0] bz; logic [15:0] lo;
  } vec_t;
  vec_t tv [10];
  gd_update_sequencer dut (
    .clk(clk), .rst(rst), .start_in(start_in), .lr_in(lr_in), .grad_in(grad_in),
    .grad_valid_in(grad_valid_in), .grad_ready_out(grad_ready_out), .rd_en_out(rd_en_out),
    .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in), .gd_lr_out(gd_lr_out),
    .gd_w_old_out(gd_w_old_out), .gd_grad_out(gd_grad_out), .gd_start_out(gd_start_out),
    .gd_w_updated_in(gd_w_updated_in), .gd_done_in(gd_done_in), .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .busy_out(busy_out), .done_out(done_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) for (int i = 0; i < 4; i++) mem[i] <= 16'((i + 1) * 256);
    else if (wr_en_out) mem[wr_addr_out] <= wr_data_out;
    if (rd_en_out) rd_data_in <= mem[rd_addr_out];
    gd_done_in <= gd_start_out | spur;
    gd_w_updated_in <= gd_w_old_out - 16'((32'(gd_lr_out) * 32'(gd_grad_out)) >> 8);
  end
  always @(negedge clk) begin
    if (gd_start_out) n_start <= n_start + 1;
    if (wr_en_out) begin
      if (n_wr < 64) wlog[n_wr] <= int'(wr_addr_out);
      n_wr <= n_wr + 1;
    end
    if (done_out) begin
      n_done <= n_done + 1;
      done_at <= cyc;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic load_mem();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic burst(input bit bub, input int lat, input string nm);
    int c0, w0, s0, d0;
    load_mem();
    w0 = n_wr;
    s0 = n_start;
    d0 = n_done;
    @(negedge clk);
    start_in = 1'b1;
    lr_in = 16'h0080;
    c0 = cyc;
    for (int i = 0; i < 40 && n_done == d0; i++) begin
      @(negedge clk);
      start_in = 1'b0;
      grad_valid_in = bub ? (i % 2 == 0) : 1'b1;
      grad_in = 16'h0200;
      #1;
    end
    grad_valid_in = 1'b0;
    chk({nm, " done_pulses"}, 32'(n_done - d0), 32'd1);
    chk({nm, " done_latency"}, 32'(done_at - c0), 32'(lat));
    chk({nm, " gd_start_count"}, 32'(n_start - s0), 32'd4);
    chk({nm, " write_count"}, 32'(n_wr - w0), 32'd4);
    for (int j = 0; j < 4; j++) begin
      chk({nm, " write_addr_order"}, 32'(wlog[w0 + j]), 32'(j));
      chk({nm, " mem"}, 32'(mem[j]), 32'(j * 256));
    end
  endtask
  initial begin
    int w0, d0;
    tv[0] = '{1'b1, 1'b0, 16'h0080, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000};
    tv[1] = '{1'b0, 1'b1, 16'h0080, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 16'h0080};
    tv[2] = '{1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 2'd1, 1'b1, 16'h0100, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 16'h0080};
    tv[3] = '{1'b0, 1'b1, 16'h0080, 1'b1, 1'b1, 2'd2, 1'b1, 16'h0200, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 16'h0080};
    tv[4] = '{1'b0, 1'b1, 16'h0080, 1'b1, 1'b1, 2'd3, 1'b1, 16'h0300, 1'b1, 2'd0, 16'h0000, 1'b0, 2'd1, 16'h0080};
    tv[5] = '{1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0400, 1'b1, 2'd1, 16'h0100, 1'b0, 2'd1, 16'h0080};
    tv[6] = '{1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 2'd2, 16'h0200, 1'b0, 2'd1, 16'h0080};
    tv[7] = '{1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 2'd3, 16'h0300, 1'b0, 2'd1, 16'h0080};
    tv[8] = '{1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 16'h0080};
    tv[9] = '{1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0080};
    start_in = 1'b1;
    lr_in = 16'h0100;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready/rd_en/gd_start", 32'({grad_ready_out, rd_en_out, gd_start_out}), 32'd0);
    chk("reset wr_en/busy/done", 32'({wr_en_out, busy_out, done_out}), 32'd0);
    chk("reset rd_addr/wr_addr", 32'({rd_addr_out, wr_addr_out}), 32'd0);
    chk("reset gd_lr", 32'(gd_lr_out), 32'd0);
    chk("reset gd_w_old/gd_grad", {gd_w_old_out, gd_grad_out}, 32'd0);
    chk("reset wr_data", 32'(wr_data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle ready", 32'(grad_ready_out), 32'd0);
    chk("idle busy", 32'(busy_out), 32'd0);
    load_mem();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start_in = tv[k].st;
      grad_valid_in = tv[k].vl;
      lr_in = tv[k].lr;
      grad_in = 16'h0200;
      #1;
      chk($sformatf("vec%0d grad_ready", k), 32'(grad_ready_out), 32'(tv[k].rdy));
      chk($sformatf("vec%0d rd_en", k), 32'(rd_en_out), 32'(tv[k].rd));
      if (tv[k].rd) chk($sformatf("vec%0d rd_addr", k), 32'(rd_addr_out), 32'(tv[k].ra));
      chk($sformatf("vec%0d gd_start", k), 32'(gd_start_out), 32'(tv[k].gs));
      if (tv[k].gs) begin
        chk($sformatf("vec%0d gd_w_old", k), 32'(gd_w_old_out), 32'(tv[k].wo));
        chk($sformatf("vec%0d gd_grad", k), 32'(gd_grad_out), 32'h0200);
      end
      chk($sformatf("vec%0d wr_en", k), 32'(wr_en_out), 32'(tv[k].we));
      if (tv[k].we) begin
        chk($sformatf("vec%0d wr_addr", k), 32'(wr_addr_out), 32'(tv[k].wa));
        chk($sformatf("vec%0d wr_data", k), 32'(wr_data_out), 32'(tv[k].wd));
      end
      chk($sformatf("vec%0d done", k), 32'(done_out), 32'(tv[k].dn));
      if (tv[k].bz != 2'd2) chk($sformatf("vec%0d busy", k), 32'(busy_out), 32'(tv[k].bz));
      chk($sformatf("vec%0d gd_lr", k), 32'(gd_lr_out), 32'(tv[k].lo));
    end
    start_in = 1'b0;
    grad_valid_in = 1'b0;
    lr_in = 16'h0080;
    for (int j = 0; j < 4; j++) chk("single mem", 32'(mem[j]), 32'(j * 256));
    burst(1'b1, 11, "bubbles");
    load_mem();
    @(negedge clk);
    start_in = 1'b1;
    lr_in = 16'h0080;
    @(negedge clk);
    start_in = 1'b0;
    grad_valid_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    grad_valid_in = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    w0 = n_wr;
    d0 = n_done;
    chk("midreset gd_lr cleared", 32'(gd_lr_out), 32'd0);
    chk("midreset busy", 32'(busy_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("midreset no writes", 32'(n_wr - w0), 32'd0);
    chk("midreset no done", 32'(n_done - d0), 32'd0);
    chk("midreset mem0 untouched", 32'(mem[0]), 32'h0100);
    chk("midreset ready idle", 32'(grad_ready_out), 32'd0);
    burst(1'b0, 8, "after_reset");
    w0 = n_wr;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("spurious no write", 32'(n_wr - w0), 32'd0);
    chk("spurious busy", 32'(busy_out), 32'd0);
    burst(1'b0, 8, "after_spurious");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
